// File: rtl/vae_layer_scheduler.sv
// Two-layer VAE decoder sequencer: walks every (neuron, input) product of
// layer 0 then layer 1 through one shared MAC and writes each finished neuron.
module vae_layer_scheduler #(
    parameter int WIDTH = 10,
    parameter int IN0   = 2,
    parameter int N0    = 18,
    parameter int N1    = 196
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mac_stall,
    output logic        busy,
    output logic        done,
    output logic        layer_sel,
    output logic [7:0]  neuron_idx,
    output logic [4:0]  input_idx,
    output logic [11:0] w_addr,
    output logic        mac_clr,
    output logic        mac_en,
    output logic        mac_last,
    output logic        res_we,
    output logic [7:0]  res_addr,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_L0_RUN = 3'd1,
        S_L0_WB  = 3'd2,
        S_L1_RUN = 3'd3,
        S_L1_WB  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [4:0]  L_K0_LAST = 5'(IN0 - 1);
    localparam logic [4:0]  L_K1_LAST = 5'(N0 - 1);
    localparam logic [7:0]  L_N0_LAST = 8'(N0 - 1);
    localparam logic [7:0]  L_N1_LAST = 8'(N1 - 1);
    localparam logic [11:0] L_L1_BASE = 12'(N0 * IN0);

    // input_idx briefly reaches K (up to N0) in the WB cycle, and the flat
    // weight address must fit the 12-bit ROM port.
    if (WIDTH < 1 || IN0 < 1 || N0 < 1 || N0 > 31 || N1 < 1 || N1 > 256 ||
        (N0 * IN0 + N1 * N0) > 4096) begin : g_bad_params
        $error("vae_layer_scheduler: parameters do not fit the index/address ports");
    end

    state_t      r_state;
    logic [7:0]  r_neuron;
    logic [4:0]  r_input;

    logic        w_is_run;
    logic        w_is_wb;
    logic        w_fire;
    logic [4:0]  w_k_last;
    logic [11:0] w_addr_l0;
    logic [11:0] w_addr_l1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_neuron <= '0;
            r_input  <= '0;
        end else if (abort && r_state != S_IDLE) begin
            r_state  <= S_IDLE;
            r_neuron <= '0;
            r_input  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state  <= S_L0_RUN;
                        r_neuron <= '0;
                        r_input  <= '0;
                    end
                end
                S_L0_RUN: begin
                    if (!mac_stall) begin
                        r_input <= r_input + 5'd1;
                        if (r_input == L_K0_LAST) r_state <= S_L0_WB;
                    end
                end
                S_L0_WB: begin
                    r_input <= '0;
                    if (r_neuron == L_N0_LAST) begin
                        r_neuron <= '0;
                        r_state  <= S_L1_RUN;
                    end else begin
                        r_neuron <= r_neuron + 8'd1;
                        r_state  <= S_L0_RUN;
                    end
                end
                S_L1_RUN: begin
                    if (!mac_stall) begin
                        r_input <= r_input + 5'd1;
                        if (r_input == L_K1_LAST) r_state <= S_L1_WB;
                    end
                end
                S_L1_WB: begin
                    r_input <= '0;
                    if (r_neuron == L_N1_LAST) begin
                        r_neuron <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_neuron <= r_neuron + 8'd1;
                        r_state  <= S_L1_RUN;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // MAC handshake: mac_en is the valid for one product and !mac_stall is the
    // ready; a product is consumed (and indices advance) only when both are high.
    assign w_is_run  = (r_state == S_L0_RUN) || (r_state == S_L1_RUN);
    assign w_is_wb   = (r_state == S_L0_WB)  || (r_state == S_L1_WB);
    assign w_fire    = w_is_run && !mac_stall;
    assign w_k_last  = (r_state == S_L1_RUN) ? L_K1_LAST : L_K0_LAST;

    assign w_addr_l0 = 12'(r_neuron) * 12'(IN0) + 12'(r_input);
    assign w_addr_l1 = L_L1_BASE + 12'(r_neuron) * 12'(N0) + 12'(r_input);

    assign layer_sel  = (r_state == S_L1_RUN) || (r_state == S_L1_WB) || (r_state == S_DONE);
    assign w_addr     = layer_sel ? w_addr_l1 : w_addr_l0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign neuron_idx = r_neuron;
    assign input_idx  = r_input;
    assign mac_en     = w_fire;
    assign mac_clr    = w_fire && (r_input == 5'd0);
    assign mac_last   = w_fire && (r_input == w_k_last);
    assign res_we     = w_is_wb;
    assign res_addr   = r_neuron;
    assign dbg_state  = r_state;

endmodule
